// File: rtl/score_pkg.sv
// Shared widths, conversion FSM state type and the shift-add-3 nibble helper
// used by the score keeper and its binary-to-BCD converter.
package score_pkg;
   localparam int SCORE_W = 13;
   localparam int BCD_W   = 4;
   localparam int SHIFT_N = 13;
   localparam int CNT_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } conv_state_t;

   // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
   function automatic logic [4*BCD_W-1:0] bcd_adjust(input logic [4*BCD_W-1:0] v);
      logic [4*BCD_W-1:0] r;
      r = v;
      for (int n = 0; n < 4; n++) begin
         if (v[n*BCD_W +: BCD_W] >= BCD_W'(5))
            r[n*BCD_W +: BCD_W] = v[n*BCD_W +: BCD_W] + BCD_W'(3);
      end
      return r;
   endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, 13 shifts, then the
// four digits are loaded together and bcd_valid pulses once.
module bin2bcd_seq
   import score_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic [SCORE_W-1:0] i_value,
   output logic [BCD_W-1:0]   o_th,
   output logic [BCD_W-1:0]   o_h,
   output logic [BCD_W-1:0]   o_t,
   output logic [BCD_W-1:0]   o_o,
   output logic               o_valid,
   output logic               o_busy,
   output conv_state_t        o_state
);
   conv_state_t          r_state;
   logic [SCORE_W-1:0]   r_bin;
   logic [4*BCD_W-1:0]   r_bcd;
   logic [CNT_W-1:0]     r_cnt;
   logic [4*BCD_W-1:0]   r_digits;
   logic                 r_valid;
   logic                 r_busy;
   logic [4*BCD_W-1:0]   w_adj;

   assign w_adj = bcd_adjust(r_bcd);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_bin    <= '0;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_digits <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_bin   <= i_value;
                  r_bcd   <= '0;
                  r_cnt   <= CNT_W'(SHIFT_N);
                  r_busy  <= 1'b1;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_bcd <= {w_adj[4*BCD_W-2:0], r_bin[SCORE_W-1]};
               r_bin <= {r_bin[SCORE_W-2:0], 1'b0};
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1))
                  r_state <= ST_DONE;
            end
            ST_DONE: begin
               // Digits are only ever loaded here, so outputs never show a partial value.
               r_digits <= r_bcd;
               r_valid  <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_th    = r_digits[4*BCD_W-1 -: BCD_W];
   assign o_h     = r_digits[3*BCD_W-1 -: BCD_W];
   assign o_t     = r_digits[2*BCD_W-1 -: BCD_W];
   assign o_o     = r_digits[BCD_W-1:0];
   assign o_valid = r_valid;
   assign o_busy  = r_busy;
   assign o_state = r_state;
endmodule

// File: rtl/score_keeper.sv
// Game score keeper: saturating score, freeze on crash, best score since reset,
// and a background BCD conversion of the score for the display block.
module score_keeper
   import score_pkg::*;
#(
   parameter int SCORE_MAX = 6399,   // must not exceed 8191
   parameter int INC       = 1
)(
   input  logic               clk2,
   input  logic               reset,
   input  logic               game_run,
   input  logic               tick,
   input  logic               crash,
   input  logic               clear,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] hi_score,
   output logic [BCD_W-1:0]   bcd_th,
   output logic [BCD_W-1:0]   bcd_h,
   output logic [BCD_W-1:0]   bcd_t,
   output logic [BCD_W-1:0]   bcd_o,
   output logic               bcd_valid,
   output logic               busy,
   output conv_state_t        dbg_state
);
   logic [SCORE_W-1:0] r_score;
   logic [SCORE_W-1:0] r_hi;
   logic [SCORE_W-1:0] r_snapshot;
   logic               r_frozen;
   logic [SCORE_W:0]   w_sum;
   logic [SCORE_W-1:0] w_next;
   logic               w_tick_ok;
   logic               w_start;
   logic               w_busy;

   // 14-bit sum so the saturation compare can never see a wrapped value.
   assign w_sum     = {1'b0, r_score} + (SCORE_W+1)'(INC);
   assign w_next    = (w_sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : w_sum[SCORE_W-1:0];
   assign w_tick_ok = tick && game_run && !r_frozen && !clear && !crash;
   assign w_start   = !w_busy && (r_score != r_snapshot);

   always_ff @(posedge clk2 or posedge reset) begin
      if (reset) begin
         r_score    <= '0;
         r_hi       <= '0;
         r_frozen   <= 1'b0;
         r_snapshot <= '0;
      end else begin
         if (clear) begin
            r_score  <= '0;
            r_frozen <= 1'b0;
         end else if (crash) begin
            if (!r_frozen) begin
               r_frozen <= 1'b1;
               if (r_score > r_hi)
                  r_hi <= r_score;
            end
         end else if (w_tick_ok) begin
            r_score <= w_next;
         end
         if (w_start)
            r_snapshot <= r_score;
      end
   end

   bin2bcd_seq u_conv (
      .clk     (clk2),
      .rst     (reset),
      .i_start (w_start),
      .i_value (r_score),
      .o_th    (bcd_th),
      .o_h     (bcd_h),
      .o_t     (bcd_t),
      .o_o     (bcd_o),
      .o_valid (bcd_valid),
      .o_busy  (w_busy),
      .o_state (dbg_state)
   );

   assign score    = r_score;
   assign hi_score = r_hi;
   assign busy     = w_busy;
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: reset, conversion timing, saturation,
// crash/hi-score, strobe priority and back-to-back ticks.
module tb_score_keeper;
   import score_pkg::*;

   logic              clk2     = 1'b0;
   logic              reset    = 1'b1;
   logic              game_run = 1'b0;
   logic              tick     = 1'b0;
   logic              crash    = 1'b0;
   logic              clear    = 1'b0;
   logic [SCORE_W-1:0] score, hi_score;
   logic [BCD_W-1:0]  bcd_th, bcd_h, bcd_t, bcd_o;
   logic              bcd_valid, busy;
   conv_state_t       dbg_state;

   int checks = 0;
   int errors = 0;

   always #5 clk2 = ~clk2;

   score_keeper dut (
      .clk2      (clk2),
      .reset     (reset),
      .game_run  (game_run),
      .tick      (tick),
      .crash     (crash),
      .clear     (clear),
      .score     (score),
      .hi_score  (hi_score),
      .bcd_th    (bcd_th),
      .bcd_h     (bcd_h),
      .bcd_t     (bcd_t),
      .bcd_o     (bcd_o),
      .bcd_valid (bcd_valid),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   function automatic logic [15:0] digits();
      return {bcd_th, bcd_h, bcd_t, bcd_o};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk2);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         @(negedge clk2);
      end
      tick = 1'b0;
   endtask

   task automatic pulse_crash();
      crash = 1'b1;
      @(negedge clk2);
      crash = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk2);
      clear = 1'b0;
   endtask

   initial begin
      int n_valid, n_busy, first_valid, bad, seen40, v;

      // Power-on reset
      cycles(3);
      check("rst_score", score, 0);
      check("rst_hi", hi_score, 0);
      check("rst_digits", digits(), 0);
      check("rst_valid", bcd_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_state", dbg_state, ST_IDLE);
      reset = 1'b0;
      n_valid = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk2);
         if (bcd_valid) n_valid++;
      end
      check("idle_no_valid", n_valid, 0);

      // 57 ticks; the last one lands with the converter idle
      game_run = 1'b1;
      ticks(56);
      cycles(50);
      check("score_56", score, 56);
      check("digits_56", digits(), 16'h0056);
      check("idle_before_57", busy, 0);
      ticks(1);
      check("score_57", score, 57);
      n_busy = 0; n_valid = 0; first_valid = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk2);
         if (busy) n_busy++;
         if (bcd_valid) begin
            n_valid++;
            if (first_valid < 0) first_valid = k;
         end
      end
      check("valid_latency", first_valid, 15);
      check("valid_pulses", n_valid, 1);
      check("busy_cycles", n_busy, 14);
      check("digits_57", digits(), 16'h0057);

      // Tick ignored while not in play
      game_run = 1'b0;
      ticks(3);
      check("no_run_tick", score, 57);
      game_run = 1'b1;

      // Crash at 1234 freezes and records the high score
      ticks(1177);
      check("score_1234", score, 1234);
      pulse_crash();
      check("hi_1234", hi_score, 1234);
      ticks(10);
      check("frozen_score", score, 1234);
      pulse_clear();
      check("clear_score", score, 0);
      check("clear_hi", hi_score, 1234);
      ticks(200);
      pulse_crash();
      check("score_200", score, 200);
      check("hi_kept", hi_score, 1234);

      // clear + crash + tick together: clear wins and the game is not frozen
      pulse_clear();
      ticks(300);
      check("score_300", score, 300);
      clear = 1'b1; crash = 1'b1; tick = 1'b1;
      @(negedge clk2);
      clear = 1'b0; crash = 1'b0; tick = 1'b0;
      check("prio_score", score, 0);
      check("prio_hi", hi_score, 1234);
      ticks(1);
      check("prio_not_frozen", score, 1);

      // Saturation at SCORE_MAX
      pulse_clear();
      ticks(6398);
      check("score_6398", score, 6398);
      ticks(7);
      check("score_sat", score, 6399);
      cycles(40);
      check("score_sat_hold", score, 6399);
      check("digits_6399", digits(), 16'h6399);
      pulse_crash();
      check("hi_6399", hi_score, 6399);

      // Back-to-back ticks: every published value must be a real score 0..40
      pulse_clear();
      cycles(40);
      check("digits_zero", digits(), 16'h0000);
      bad = 0; seen40 = 0;
      for (int k = 0; k < 70; k++) begin
         tick = (k < 40);
         @(negedge clk2);
         if (bcd_valid) begin
            if (bcd_th > 9 || bcd_h > 9 || bcd_t > 9 || bcd_o > 9) bad++;
            v = bcd_th * 1000 + bcd_h * 100 + bcd_t * 10 + bcd_o;
            if (v > 40) bad++;
            if (v == 40) seen40 = 1;
         end
      end
      tick = 1'b0;
      check("stream_values", bad, 0);
      check("stream_seen40", seen40, 1);
      check("stream_digits", digits(), 16'h0040);
      check("stream_score", score, 40);

      // Reset in the middle of a conversion
      ticks(5);
      cycles(3);
      check("mid_busy", busy, 1);
      reset = 1'b1;
      #1;
      check("async_score", score, 0);
      check("async_busy", busy, 0);
      cycles(3);
      check("mr_score", score, 0);
      check("mr_hi", hi_score, 0);
      check("mr_digits", digits(), 0);
      check("mr_valid", bcd_valid, 0);
      check("mr_state", dbg_state, ST_IDLE);
      reset = 1'b0;
      n_valid = 0; n_busy = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk2);
         if (bcd_valid) n_valid++;
         if (busy) n_busy++;
      end
      check("post_rst_valid", n_valid, 0);
      check("post_rst_busy", n_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: observed timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter SCORE_MAX, default 6399, is the saturation ceiling of the score; it SHALL be at most 8191.
REQ-002 Parameter INC, default 1, is the amount added per accepted tick.
REQ-003 Port clk2  input  1  is the single clock; all state SHALL be updated on its rising edge.
REQ-004 Port reset  input  1  is the asynchronous, active-high reset.
REQ-005 Port game_run  input  1  SHALL be 1 while the game is in play.
REQ-006 Port tick  input  1  is a one-cycle score-increment strobe.
REQ-007 Port crash  input  1  is a one-cycle game-over strobe.
REQ-008 Port clear  input  1  is a one-cycle new-game strobe.
REQ-009 Port score  output  13  is the binary score fed to the display block.
REQ-010 Port hi_score  output  13  is the best score since reset.
REQ-011 Ports bcd_th, bcd_h, bcd_t, bcd_o  output  4 each  are the BCD thousands, hundreds, tens and ones digits of the last converted score.
REQ-012 Port bcd_valid  output  1  SHALL pulse for one cycle when the BCD digits update.
REQ-013 Port busy  output  1  SHALL be high while a conversion is in progress.

Function
REQ-014 The block SHALL act on control strobes in the priority order clear > crash > tick.
REQ-015 On clear, the block SHALL set score to 0 and the frozen flag to 0, SHALL leave hi_score unchanged, and SHALL ignore a crash or tick in the same cycle.
REQ-016 On crash while not frozen, the block SHALL set frozen, and hi_score SHALL become score if score > hi_score, visible on the next cycle.
REQ-017 A crash while already frozen SHALL have no effect.
REQ-018 A tick SHALL be accepted only when game_run=1, frozen=0 and no clear or crash is present in the same cycle.
REQ-019 An accepted tick SHALL set score to min(score+INC, SCORE_MAX), computed at 14 bits with no wrap-around.
REQ-020 The conversion FSM SHALL have states IDLE, SHIFT and DONE.
REQ-021 In IDLE, when score differs from the internal snapshot, the FSM SHALL capture score into the snapshot, clear the shift register, set the bit counter to 13 and enter SHIFT; busy SHALL be high from that edge.
REQ-022 In SHIFT, each cycle the FSM SHALL add 3 to every BCD nibble that is >= 5 and then shift left one bit from the snapshot; after 13 shifts it SHALL enter DONE.
REQ-023 In DONE, the FSM SHALL load the four bcd_* outputs together, pulse bcd_valid for one cycle, drop busy and return to IDLE.
REQ-024 bcd_valid SHALL assert exactly 15 cycles after the edge on which score changed, provided the FSM was idle at that edge.
REQ-025 A score change during SHIFT or DONE SHALL NOT disturb the conversion in flight; the newest score SHALL be converted on the first IDLE cycle afterwards, and intermediate values may be skipped.
REQ-026 The bcd_* outputs SHALL always form one consistent snapshot and SHALL never show a partially converted value.

Reset
REQ-027 While reset=1, the block SHALL hold score=0, hi_score=0, all bcd_*=0, bcd_valid=0, busy=0, frozen=0, snapshot=0 and FSM state IDLE, independent of clk2.
REQ-028 Reset asserted mid-conversion SHALL abort the conversion with no bcd_valid pulse; after release, the block SHALL start no conversion until score changes.

Structure
REQ-029 Package score_pkg SHALL hold SCORE_W=13, BCD_W=4, the FSM state type and the shift count 13; the display block SHALL share SCORE_W from it.
REQ-030 The shift-add-3 datapath and FSM SHALL be a single sub-module bin2bcd_seq (start/snapshot in, digits/valid/busy out); score_keeper SHALL contain the score, freeze and hi-score logic.

Verification
REQ-031 Assert reset for 3 cycles mid-activity -> every output 0, and no bcd_valid for 20 cycles after release.
REQ-032 Apply 57 ticks with game_run=1 -> score=57; bcd_valid 15 cycles after the last tick with digits 0,0,5,7; busy high for exactly 14 cycles before it.
REQ-033 Apply 6405 ticks -> score saturates at 6399 and stays there; final digits 6,3,9,9.
REQ-034 Crash at score 1234 -> hi_score=1234 next cycle; 10 further ticks leave score at 1234; clear -> score 0, hi_score 1234; next game crash at 200 -> hi_score stays 1234.
REQ-035 Assert clear, crash and tick in the same cycle at score 300 -> score 0, not frozen, hi_score unchanged.
REQ-036 Apply ticks on every cycle for 40 cycles with game_run=1 -> no bcd_valid pulse shows a value that never existed; the final bcd equals 40 within 30 cycles of the last tick.
